pulse_stretcher_multi: RTL and testbench

- Multi-channel, parametrised successor to the single-shot half-second pulse stretcher used for game events (hit, sound, game-over).
- Each channel detects a rising edge on its trigger and holds its output high for exactly DURATION clock cycles.
- Each channel also emits one-cycle start and expiry strobes.
- Adds configurable retrigger mode, a global clear and per-channel status. Sits between game-logic event sources and the display/sound/end-of-game consumers.

---
 rtl/pulse_stretcher_multi_if.sv | 30 +++
 rtl/pulse_stretcher_multi.sv | 128 ++++++++++++
 tb/tb_pulse_stretcher_multi.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pulse_stretcher_multi_if.sv
// Event-source to pulse-stretcher bundle: per-channel triggers and global clear in,
// stretched pulses, start/expiry strobes and aggregate busy out.
interface pulse_stretcher_multi_if #(
    parameter int N_CH = 3
);
    logic [N_CH-1:0] trig;
    logic            clear;
    logic [N_CH-1:0] active;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] done;
    logic            busy;

    modport master (
        output trig,
        output clear,
        input  active,
        input  rise,
        input  done,
        input  busy
    );

    modport slave (
        input  trig,
        input  clear,
        output active,
        output rise,
        output done,
        output busy
    );
endinterface

// File: rtl/pulse_stretcher_multi.sv
// Multi-channel edge-triggered pulse stretcher; optional post-expiry dead time via PULSE_HOLDOFF_EN.
// Latency: active/rise one cycle after the sampled trigger edge; active lasts DURATION cycles.
// Backpressure: none; clear aborts all channels, and edges that cannot be honoured are dropped.
module pulse_stretcher_multi #(
    parameter int N_CH           = 3,
    parameter int CNT_W          = 25,
    parameter int DURATION       = 25_000_000,
    parameter int RETRIGGER      = 1,
    parameter int HOLDOFF_CYCLES = 1000
) (
    input logic                    clk,
    input logic                    reset,
    pulse_stretcher_multi_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1
`ifdef PULSE_HOLDOFF_EN
        ,
        ST_HOLDOFF = 2'd2
`endif
    } state_t;

    localparam logic [CNT_W-1:0] DUR_LOAD = CNT_W'(DURATION - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef PULSE_HOLDOFF_EN
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);
`endif

    state_t           state_q [N_CH];
    state_t           state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [N_CH-1:0]  trig_hist_q, trig_hist_d;
    logic [N_CH-1:0]  active_q, active_d;
    logic [N_CH-1:0]  rise_q, rise_d;
    logic [N_CH-1:0]  done_q, done_d;
    logic             busy_q, busy_d;
    logic [N_CH-1:0]  edge_det;

    always_comb begin
        edge_det    = bus.trig & ~trig_hist_q;
        trig_hist_d = bus.trig;
        active_d    = '0;
        rise_d      = '0;
        done_d      = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (bus.clear) begin
                // Clear wins over any same-cycle edge; that edge is simply lost.
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (edge_det[i]) begin
                            state_d[i] = ST_ACTIVE;
                            cnt_d[i]   = DUR_LOAD;
                            rise_d[i]  = 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (RETRIGGER != 0 && edge_det[i]) begin
                            cnt_d[i] = DUR_LOAD;
                        end else if (cnt_q[i] == '0) begin
                            done_d[i] = 1'b1;
`ifdef PULSE_HOLDOFF_EN
                            state_d[i] = ST_HOLDOFF;
                            cnt_d[i]   = HOLD_LOAD;
`else
                            state_d[i] = ST_IDLE;
`endif
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
`ifdef PULSE_HOLDOFF_EN
                    ST_HOLDOFF: begin
                        // Edges here, including on the exit cycle, are deliberately ignored.
                        if (cnt_q[i] == '0) begin
                            state_d[i] = ST_IDLE;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
`endif
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            active_d[i] = (state_d[i] == ST_ACTIVE);
        end
        busy_d = |active_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // All-ones history keeps a trigger already high at release from firing.
            trig_hist_q <= '1;
            active_q    <= '0;
            rise_q      <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            trig_hist_q <= trig_hist_d;
            active_q    <= active_d;
            rise_q      <= rise_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign bus.active = active_q;
    assign bus.rise   = rise_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_pulse_stretcher_multi.sv
// Directed bench for pulse_stretcher_multi: two instances (retrigger on/off) share one stimulus.
module tb_pulse_stretcher_multi;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] trig;
    logic       clear;
    int         tests = 0;
    int         fails = 0;
    int         n;

    always #5 clk = ~clk;

    pulse_stretcher_multi_if #(.N_CH(2)) bus_rt ();
    pulse_stretcher_multi_if #(.N_CH(2)) bus_nr ();

    assign bus_rt.trig  = trig;
    assign bus_rt.clear = clear;
    assign bus_nr.trig  = trig;
    assign bus_nr.clear = clear;

    pulse_stretcher_multi #(
        .N_CH(2), .CNT_W(4), .DURATION(8), .RETRIGGER(1), .HOLDOFF_CYCLES(4)
    ) dut_rt (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_rt.slave)
    );

    pulse_stretcher_multi #(
        .N_CH(2), .CNT_W(4), .DURATION(8), .RETRIGGER(0), .HOLDOFF_CYCLES(4)
    ) dut_nr (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nr.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        trig  = 2'b00;
        clear = 1'b0;
        repeat (k) step();
    endtask

    initial begin
        reset = 1'b0;
        trig  = 2'b00;
        clear = 1'b0;
        repeat (3) step();
        check("reset.active", 32'(bus_rt.active), 32'(2'b00));
        check("reset.rise",   32'(bus_rt.rise),   32'(2'b00));
        check("reset.done",   32'(bus_rt.done),   32'(2'b00));
        check("reset.busy",   32'(bus_rt.busy),   32'(1'b0));
        reset = 1'b1;
        idle(12);

        // Basic single pulse on channel 0.
        for (int c = 10; c <= 20; c++) begin
            trig = (c == 10) ? 2'b01 : 2'b00;
            step();
            n = c + 1;
            check($sformatf("basic.active@%0d", n), 32'(bus_rt.active), 32'((n >= 11 && n <= 18) ? 2'b01 : 2'b00));
            check($sformatf("basic.rise@%0d", n),   32'(bus_rt.rise),   32'((n == 11) ? 2'b01 : 2'b00));
            check($sformatf("basic.done@%0d", n),   32'(bus_rt.done),   32'((n == 19) ? 2'b01 : 2'b00));
            check($sformatf("basic.busy@%0d", n),   32'(bus_rt.busy),   32'(n >= 11 && n <= 18));
        end
        idle(12);

        // Edge mid-window: restart with retrigger, ignored without.
        for (int c = 10; c <= 25; c++) begin
            trig = (c == 10 || c == 15) ? 2'b01 : 2'b00;
            step();
            n = c + 1;
            check($sformatf("retrig.rt.active@%0d", n), 32'(bus_rt.active), 32'((n >= 11 && n <= 23) ? 2'b01 : 2'b00));
            check($sformatf("retrig.rt.rise@%0d", n),   32'(bus_rt.rise),   32'((n == 11) ? 2'b01 : 2'b00));
            check($sformatf("retrig.rt.done@%0d", n),   32'(bus_rt.done),   32'((n == 24) ? 2'b01 : 2'b00));
            check($sformatf("retrig.nr.active@%0d", n), 32'(bus_nr.active), 32'((n >= 11 && n <= 18) ? 2'b01 : 2'b00));
            check($sformatf("retrig.nr.rise@%0d", n),   32'(bus_nr.rise),   32'((n == 11) ? 2'b01 : 2'b00));
            check($sformatf("retrig.nr.done@%0d", n),   32'(bus_nr.done),   32'((n == 19) ? 2'b01 : 2'b00));
        end
        idle(12);

        // Clear aborts channel 1 and beats a same-cycle edge on channel 0.
        for (int c = 10; c <= 20; c++) begin
            trig  = (c == 10) ? 2'b10 : ((c == 13) ? 2'b01 : 2'b00);
            clear = (c == 13);
            step();
            n = c + 1;
            check($sformatf("clear.active@%0d", n),    32'(bus_rt.active), 32'((n >= 11 && n <= 13) ? 2'b10 : 2'b00));
            check($sformatf("clear.rise@%0d", n),      32'(bus_rt.rise),   32'((n == 11) ? 2'b10 : 2'b00));
            check($sformatf("clear.done@%0d", n),      32'(bus_rt.done),   32'(2'b00));
            check($sformatf("clear.busy@%0d", n),      32'(bus_rt.busy),   32'(n >= 11 && n <= 13));
            check($sformatf("clear.nr.active@%0d", n), 32'(bus_nr.active), 32'((n >= 11 && n <= 13) ? 2'b10 : 2'b00));
        end
        idle(12);

        // Trigger held through reset release, later fresh edge, then reset mid-window.
        reset = 1'b0;
        trig  = 2'b01;
        step();
        step();
        for (int c = 10; c <= 27; c++) begin
            reset = (c == 23) ? 1'b0 : 1'b1;
            trig  = (c <= 18 || c == 20) ? 2'b01 : 2'b00;
            step();
            n = c + 1;
            check($sformatf("rst.active@%0d", n), 32'(bus_rt.active), 32'((n >= 21 && n <= 23) ? 2'b01 : 2'b00));
            check($sformatf("rst.rise@%0d", n),   32'(bus_rt.rise),   32'((n == 21) ? 2'b01 : 2'b00));
            check($sformatf("rst.done@%0d", n),   32'(bus_rt.done),   32'(2'b00));
            check($sformatf("rst.busy@%0d", n),   32'(bus_rt.busy),   32'(n >= 21 && n <= 23));
        end
        reset = 1'b1;
        idle(12);

        // Simultaneous start on both channels, then an edge on channel 0's last active cycle.
        for (int c = 10; c <= 29; c++) begin
            trig = (c == 10) ? 2'b11 : ((c == 18) ? 2'b01 : 2'b00);
            step();
            n = c + 1;
            check($sformatf("simul.rt.active@%0d", n), 32'(bus_rt.active), 32'({(n >= 11 && n <= 18), (n >= 11 && n <= 26)}));
            check($sformatf("simul.rt.rise@%0d", n),   32'(bus_rt.rise),   32'((n == 11) ? 2'b11 : 2'b00));
            check($sformatf("simul.rt.done@%0d", n),   32'(bus_rt.done),   32'({(n == 19), (n == 27)}));
            check($sformatf("simul.nr.active@%0d", n), 32'(bus_nr.active), 32'((n >= 11 && n <= 18) ? 2'b11 : 2'b00));
            check($sformatf("simul.nr.done@%0d", n),   32'(bus_nr.done),   32'((n == 19) ? 2'b11 : 2'b00));
        end
        idle(12);

`ifdef PULSE_HOLDOFF_EN
        // Dead time after expiry: edges at 20 and 22 (exit cycle) ignored, 25 starts anew.
        for (int c = 10; c <= 29; c++) begin
            trig = (c == 10 || c == 20 || c == 22 || c == 25) ? 2'b01 : 2'b00;
            step();
            n = c + 1;
            check($sformatf("hold.active@%0d", n),  32'(bus_rt.active), 32'(((n >= 11 && n <= 18) || n >= 26) ? 2'b01 : 2'b00));
            check($sformatf("hold.rise@%0d", n),    32'(bus_rt.rise),   32'((n == 11 || n == 26) ? 2'b01 : 2'b00));
            check($sformatf("hold.done@%0d", n),    32'(bus_rt.done),   32'((n == 19) ? 2'b01 : 2'b00));
            check($sformatf("hold.nr.rise@%0d", n), 32'(bus_nr.rise),   32'((n == 11 || n == 26) ? 2'b01 : 2'b00));
        end
`else
        // No dead time: an edge on the done cycle restarts immediately.
        for (int c = 10; c <= 29; c++) begin
            trig = (c == 10 || c == 19) ? 2'b01 : 2'b00;
            step();
            n = c + 1;
            check($sformatf("nohold.active@%0d", n),  32'(bus_rt.active), 32'(((n >= 11 && n <= 18) || (n >= 20 && n <= 27)) ? 2'b01 : 2'b00));
            check($sformatf("nohold.rise@%0d", n),    32'(bus_rt.rise),   32'((n == 11 || n == 20) ? 2'b01 : 2'b00));
            check($sformatf("nohold.done@%0d", n),    32'(bus_rt.done),   32'((n == 19 || n == 28) ? 2'b01 : 2'b00));
            check($sformatf("nohold.nr.rise@%0d", n), 32'(bus_nr.rise),   32'((n == 11 || n == 20) ? 2'b01 : 2'b00));
        end
`endif
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
